led_driver: RTL and testbench

LED_DRIVER -- requirements
Module: led_driver

---
 rtl/led_drv_pkg.sv | 27 ++
 rtl/led_driver_tick_gen.sv | 23 ++
 rtl/led_driver.sv | 98 +++++++++
 tb/tb_led_driver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_drv_pkg.sv
// Shared definitions for the LED driver: mode encoding, config reset value
// and the duty endpoints that bypass the PWM compare.
package led_drv_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STEADY = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_CHASE  = 2'b11
  } mode_e;

  localparam logic [7:0]  CFG_RESET  = 8'h1F;
  localparam logic [3:0]  DUTY_OFF   = 4'h0;
  localparam logic [3:0]  DUTY_FULL  = 4'hF;
  localparam logic [15:0] CHASE_INIT = 16'h0001;

  // Duty 15 must be fully on, which a plain (cnt < duty) compare cannot give.
  function automatic logic pwm_on_f(input logic [3:0] duty, input logic [3:0] cnt);
    logic on;
    on = 1'b0;
    if (duty == DUTY_OFF)       on = 1'b0;
    else if (duty == DUTY_FULL) on = 1'b1;
    else                        on = (cnt < duty);
    return on;
  endfunction

endpackage

// File: rtl/led_driver_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the last count as the PWM step tick.
module tick_gen #(
  parameter int PRESCALE = 100
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)            cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + CW'(1);
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_driver.sv
// LED driver: PWM dimming of a 16-bit LED pattern with off/steady/blink/chase
// modes selected through a small config register.
module led_driver
  import led_drv_pkg::*;
#(
  parameter int PRESCALE      = 100,
  parameter int BLINK_PERIODS = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] leds_reg_i,
  input  logic [7:0]  cfg_data_i,
  input  logic        we_cfg_i,
  output logic [15:0] leds_o
);

  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

  // Reserved bits [7:6] always read as zero, so only the low six are stored.
  logic [5:0]    cfg_q;
  logic [3:0]    pwm_cnt_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic [15:0]   chase_q;
  logic [15:0]   leds_q;
  logic [15:0]   leds_next;

  logic  tick;
  logic  period_end;
  logic  blink_wrap;
  logic  mode_chg;
  logic  pwm_on;
  mode_e mode;
  logic  cfg_rsvd_unused;

  assign cfg_rsvd_unused = ^cfg_data_i[7:6];

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick    (tick)
  );

  assign mode       = mode_e'(cfg_q[5:4]);
  assign pwm_on     = pwm_on_f(cfg_q[3:0], pwm_cnt_q);
  assign period_end = tick && (pwm_cnt_q == 4'hF);
  assign blink_wrap = period_end && (blink_cnt_q == BLINK_LAST);
  assign mode_chg   = we_cfg_i && (cfg_data_i[5:4] != cfg_q[5:4]);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       cfg_q <= CFG_RESET[5:0];
    else if (we_cfg_i) cfg_q <= cfg_data_i[5:0];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   pwm_cnt_q <= 4'h0;
    else if (tick) pwm_cnt_q <= pwm_cnt_q + 4'h1;
  end

  // A mode change restarts blink/chase and wins over a coincident period end.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      chase_q       <= CHASE_INIT;
    end else if (mode_chg) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      chase_q       <= CHASE_INIT;
    end else if (blink_wrap) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
      chase_q       <= {chase_q[14:0], chase_q[15]};
    end else if (period_end) begin
      blink_cnt_q   <= blink_cnt_q + BW'(1);
    end
  end

  always_comb begin
    leds_next = 16'h0000;
    unique case (mode)
      MODE_OFF:    leds_next = 16'h0000;
      MODE_STEADY: leds_next = pwm_on ? leds_reg_i : 16'h0000;
      MODE_BLINK:  leds_next = (pwm_on && blink_phase_q) ? leds_reg_i : 16'h0000;
      MODE_CHASE:  leds_next = pwm_on ? chase_q : 16'h0000;
      default:     leds_next = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) leds_q <= 16'h0000;
    else         leds_q <= leds_next;
  end

  assign leds_o = leds_q;

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: model derives LED output from elapsed
// cycle count, last mode-change time and the config value.
module tb_led_driver;

  localparam int P  = 4;
  localparam int BP = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] leds_reg_i;
  logic [7:0]  cfg_data_i;
  logic        we_cfg_i;
  logic [15:0] leds_o;

  int          total = 0;
  int          bad   = 0;
  int          n     = 0;
  int          e     = 0;
  logic [7:0]  cfg_m = 8'h1F;

  led_driver #(.PRESCALE(P), .BLINK_PERIODS(BP)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .leds_reg_i (leds_reg_i),
    .cfg_data_i (cfg_data_i),
    .we_cfg_i   (we_cfg_i),
    .leds_o     (leds_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit expired, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // n = edges since reset release, e = edge at which the mode last changed.
  function automatic logic [15:0] model_out(int n_, int e_, logic [7:0] c, logic [15:0] lr);
    int          pwm, per, tog, duty;
    logic        on, phase;
    logic [15:0] chase, r;
    pwm   = (n_ / P) % 16;
    duty  = int'(c[3:0]);
    if (duty == 0)       on = 1'b0;
    else if (duty == 15) on = 1'b1;
    else                 on = (pwm < duty);
    per   = n_ / (16 * P) - e_ / (16 * P);
    tog   = per / BP;
    phase = ((tog % 2) == 0);
    chase = 16'h0001 << (tog % 16);
    case (c[5:4])
      2'b00:   r = 16'h0000;
      2'b01:   r = on ? lr : 16'h0000;
      2'b10:   r = (on && phase) ? lr : 16'h0000;
      default: r = on ? chase : 16'h0000;
    endcase
    return r;
  endfunction

  task automatic cyc(output logic [15:0] exp);
    logic [7:0] nc;
    exp = model_out(n, e, cfg_m, leds_reg_i);
    @(posedge clk_i);
    n++;
    if (we_cfg_i) begin
      nc = {2'b00, cfg_data_i[5:0]};
      if (nc[5:4] != cfg_m[5:4]) e = n;
      cfg_m = nc;
    end
    #1;
  endtask

  task automatic model_reset();
    n = 0;
    e = 0;
    cfg_m = 8'h1F;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    leds_reg_i = 16'hA5A5;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if (leds_o !== 16'h0000) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=0000", leds_o);
    end
    reset_i = 1'b0;
    model_reset();
    for (int i = 0; i < 70; i++) begin
      cyc(exp);
      total++;
      if (leds_o !== exp) begin
        bad++;
        $display("FAIL reset_release c%0d got=%h exp=%h", i, leds_o, exp);
      end
    end
  endtask

  task automatic test_pwm_duty();
    logic [15:0] exp;
    int          on_cnt;
    leds_reg_i = 16'hFFFF;
    we_cfg_i = 1'b1;
    cfg_data_i = 8'h14;
    cyc(exp);
    we_cfg_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(exp);
      total++;
      if (leds_o !== exp) begin
        bad++;
        $display("FAIL pwm_duty c%0d got=%h exp=%h", i, leds_o, exp);
      end
    end
    on_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(exp);
      if (leds_o === 16'hFFFF) on_cnt++;
    end
    total++;
    if (on_cnt != 16) begin
      bad++;
      $display("FAIL pwm_on_cycles got=%0d exp=16", on_cnt);
    end
  endtask

  task automatic test_blink();
    logic [15:0] exp;
    leds_reg_i = 16'h00FF;
    we_cfg_i = 1'b1;
    cfg_data_i = 8'h2F;
    cyc(exp);
    we_cfg_i = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cyc(exp);
      total++;
      if (leds_o !== exp) begin
        bad++;
        $display("FAIL blink c%0d got=%h exp=%h", i, leds_o, exp);
      end
    end
  endtask

  task automatic test_duty_only();
    logic [15:0] exp;
    logic [7:0]  wr [2];
    wr[0] = 8'h27;
    wr[1] = 8'hE9;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 50 + $urandom_range(0, 80); i++) begin
        cyc(exp);
        total++;
        if (leds_o !== exp) begin
          bad++;
          $display("FAIL duty_only_pre c%0d got=%h exp=%h", i, leds_o, exp);
        end
      end
      we_cfg_i = 1'b1;
      cfg_data_i = wr[k];
      cyc(exp);
      we_cfg_i = 1'b0;
      for (int i = 0; i < 300; i++) begin
        cyc(exp);
        total++;
        if (leds_o !== exp) begin
          bad++;
          $display("FAIL duty_only_post w%0d c%0d got=%h exp=%h", k, i, leds_o, exp);
        end
      end
    end
  endtask

  task automatic test_chase();
    logic [15:0] exp;
    leds_reg_i = 16'h1234;
    we_cfg_i = 1'b1;
    cfg_data_i = 8'h3F;
    cyc(exp);
    we_cfg_i = 1'b0;
    for (int i = 0; i < 16 * 128 + 300; i++) begin
      if ((i % 97) == 0) leds_reg_i = 16'($urandom);
      cyc(exp);
      total++;
      if (leds_o !== exp) begin
        bad++;
        $display("FAIL chase c%0d got=%h exp=%h", i, leds_o, exp);
      end
    end
  endtask

  task automatic test_reset_mid_chase();
    logic [15:0] exp;
    bit          seen;
    we_cfg_i = 1'b1;
    cfg_data_i = 8'h1F;
    cyc(exp);
    cfg_data_i = 8'h3F;
    cyc(exp);
    we_cfg_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      cyc(exp);
      total++;
      if (leds_o !== exp) begin
        bad++;
        $display("FAIL chase_to_0100 c%0d got=%h exp=%h", i, leds_o, exp);
      end
      if (leds_o === 16'h0100) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL chase_0100_timeout got=%h exp=0100", leds_o);
    end
    repeat (20) cyc(exp);
    #2;
    reset_i = 1'b1;
    #1;
    total++;
    if (leds_o !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0000", leds_o);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    model_reset();
    leds_reg_i = 16'h5AC3;
    cyc(exp);
    total++;
    if (leds_o !== leds_reg_i) begin
      bad++;
      $display("FAIL post_reset_steady got=%h exp=%h", leds_o, leds_reg_i);
    end
    for (int i = 0; i < 80; i++) begin
      cyc(exp);
      total++;
      if (leds_o !== exp) begin
        bad++;
        $display("FAIL post_reset c%0d got=%h exp=%h", i, leds_o, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 24; i++) begin
      we_cfg_i = 1'b1;
      cfg_data_i = 8'($urandom);
      leds_reg_i = 16'($urandom);
      cyc(exp);
      total++;
      if (leds_o !== exp) begin
        bad++;
        $display("FAIL back_to_back c%0d got=%h exp=%h", i, leds_o, exp);
      end
    end
    we_cfg_i = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int i = 0; i < 3000; i++) begin
      we_cfg_i = ($urandom_range(0, 39) == 0);
      cfg_data_i = 8'($urandom);
      if ($urandom_range(0, 7) == 0) leds_reg_i = 16'($urandom);
      cyc(exp);
      total++;
      if (leds_o !== exp) begin
        bad++;
        $display("FAIL random c%0d got=%h exp=%h cfg=%h", i, leds_o, exp, cfg_m);
      end
    end
    we_cfg_i = 1'b0;
  endtask

  initial begin
    reset_i    = 1'b1;
    we_cfg_i   = 1'b0;
    cfg_data_i = 8'h00;
    leds_reg_i = 16'h0000;
    test_reset();
    test_pwm_duty();
    test_blink();
    test_duty_only();
    test_chase();
    test_reset_mid_chase();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
